// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE, WAIT, DONE)
//   op_t      : latched access kind (OP_RD, OP_WR)
//   WAIT_MIN/WAIT_MAX : legal range of the wait-state parameter
//   wait_load : counter preload for a given wait-state count
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  // Counter counts down to zero inside WAIT, so it is loaded with one less
  // than the number of wait cycles. Out-of-range settings are clamped.
  function automatic logic [3:0] wait_load(input int ws);
    int c;
    c = (ws < WAIT_MIN) ? WAIT_MIN : ((ws > WAIT_MAX) ? WAIT_MAX : ws);
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// Single-port word RAM: synchronous write, registered read, enable-gated.
// The array and the read register carry no reset; contents are undefined
// at power-up.
//   clock : rising-edge clock
//   en    : access enable for this edge
//   we    : 1 = write wdata to addr, 0 = load rdata from addr
//   addr  : word address
//   wdata : write data
//   rdata : read data, updated only by read accesses
module sync_word_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder for the pipeline memory stage. Accepts a load or
// store, stalls the pipeline for WAIT_STATES+1 cycles, performs the RAM
// access on the last wait edge, then spends one DONE cycle unstalled before
// returning to IDLE. Misaligned / out-of-range accesses complete normally
// but skip the RAM and pulse mem_Error in DONE.
//   clock, reset : clock, asynchronous active-high reset
//   mem_Addr     : byte address of the access
//   mem_WrData   : store data
//   mem_WrEn     : store request (wins when both enables are high)
//   mem_RdEn     : load request
//   mem_RdData   : load data, valid from DONE until the next load completes
//   mem_Stall    : pipeline must hold its request while high
//   mem_Error    : one-cycle pulse in DONE for a faulting access
module data_memory_responder
  import data_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_Addr,
  input  logic [31:0] mem_WrData,
  input  logic        mem_WrEn,
  input  logic        mem_RdEn,
  output logic [31:0] mem_RdData,
  output logic        mem_Stall,
  output logic        mem_Error
);

  localparam logic [3:0] CNT_LOAD = wait_load(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  op_t                   op_q, op_d;
  logic                  skip_q, skip_d;     // address fault: RAM untouched
  logic                  fault_q, fault_d;   // error to report in DONE
  logic                  error_q, error_d;
  logic                  rd_zero_q, rd_zero_d; // force mem_RdData to 0

  logic        req;
  logic [31:0] offset;
  logic        addr_bad;
  logic        last_wait;
  logic        ram_en;
  logic [31:0] ram_rdata;

  assign req    = mem_WrEn | mem_RdEn;
  assign offset = mem_Addr - BASE_ADDR;
  // Below-base wraps the subtraction, so it is tested separately.
  assign addr_bad = (offset[1:0] != 2'b00)
                  | (mem_Addr < BASE_ADDR)
                  | ({3'b000, offset[31:2]} >= (33'd1 << ADDR_WIDTH));

  assign last_wait = (state_q == WAIT) && (cnt_q == 4'd0);
  assign ram_en    = last_wait && !skip_q;

  // Stall is combinational on the request in IDLE so the pipeline holds in
  // the accept cycle; reset forces it low without waiting for a clock.
  assign mem_Stall  = !reset && ((state_q == WAIT) || ((state_q == IDLE) && req));
  assign mem_RdData = rd_zero_q ? 32'h0 : ram_rdata;
  assign mem_Error  = error_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    skip_d    = skip_q;
    fault_d   = fault_q;
    error_d   = 1'b0;
    rd_zero_d = rd_zero_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          word_d  = offset[ADDR_WIDTH+1:2];
          wdata_d = mem_WrData;
          op_d    = mem_WrEn ? OP_WR : OP_RD;
          skip_d  = addr_bad;
          fault_d = addr_bad | (mem_WrEn & mem_RdEn);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          error_d = fault_q;
          if (op_q == OP_RD) begin
            rd_zero_d = skip_q;
          end
        end
      end
      DONE: begin
        // The request is still on the inputs here; it is deliberately ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      word_q    <= '0;
      wdata_q   <= 32'h0;
      op_q      <= OP_RD;
      skip_q    <= 1'b0;
      fault_q   <= 1'b0;
      error_q   <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      skip_q    <= skip_d;
      fault_q   <= fault_d;
      error_q   <= error_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  sync_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_W    (32)
  ) u_ram (
    .clock(clock),
    .en   (ram_en),
    .we   (op_q == OP_WR),
    .addr (word_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;
  import data_mem_pkg::*;

  localparam int          AW   = 10;
  localparam int          WS   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_Addr;
  logic [31:0] mem_WrData;
  logic        mem_WrEn;
  logic        mem_RdEn;
  logic [31:0] mem_RdData;
  logic        mem_Stall;
  logic        mem_Error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd;

  always #5 clock = ~clock;

  data_memory_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_Addr  (mem_Addr),
    .mem_WrData(mem_WrData),
    .mem_WrEn  (mem_WrEn),
    .mem_RdEn  (mem_RdEn),
    .mem_RdData(mem_RdData),
    .mem_Stall (mem_Stall),
    .mem_Error (mem_Error)
  );

  // mem_Error must never coincide with mem_Stall.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      checks++;
      if (mem_Error === 1'b1 && mem_Stall === 1'b1) begin
        errors++;
        $display("FAIL error_with_stall: error=%b stall=%b required error=0 while stalled",
                 mem_Error, mem_Stall);
      end
    end
  end

  // Push the expected completion, update the reference model, then drive.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic re);
    logic [31:0] off;
    logic        bad;
    int          w;
    exp_t        e;
    off = a - BASE;
    w   = int'(off >> 2);
    bad = (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= (32'd1 << AW));
    if (we) begin
      if (!bad) model[w] = wd;
    end else begin
      last_rd = bad ? 32'h0 : model[w];
    end
    e.rd  = last_rd;
    e.err = bad | (we & re);
    sb.push_back(e);
    @(posedge clock);
    #1;
    mem_Addr   = a;
    mem_WrData = wd;
    mem_WrEn   = we;
    mem_RdEn   = re;
  endtask

  // Count stalled negedges; returns at the first unstalled one (DONE).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!mem_Stall) break;
      n++;
    end
  endtask

  task automatic release_req();
    @(posedge clock);
    #1;
    mem_WrEn = 1'b0;
    mem_RdEn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_Addr = 32'h0; mem_WrData = 32'h0; mem_WrEn = 1'b0; mem_RdEn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (mem_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", mem_Stall); end
    checks++; if (mem_Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", mem_Error); end
    checks++; if (mem_RdData !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h want 0", mem_RdData); end
    mem_RdEn = 1'b1;
    #1;
    checks++; if (mem_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall_req: got %b want 0", mem_Stall); end
    mem_RdEn = 1'b0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    last_rd = 32'h0;
  endtask

  // Store then load the same word; each access is checked on completion.
  task automatic test_write_read();
    logic [31:0] ad [2] = '{32'h10, 32'h10};
    logic        wr [2] = '{1'b1, 1'b0};
    int n; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(ad[i], 32'hDEADBEEF, wr[i], !wr[i]);
      wait_done(n);
      e = sb.pop_front();
      checks++; if (n !== WS + 1) begin errors++; $display("FAIL wr_rd_stall[%0d]: got %0d want %0d", i, n, WS + 1); end
      checks++; if (mem_RdData !== e.rd) begin errors++; $display("FAIL wr_rd_data[%0d]: got %h want %h", i, mem_RdData, e.rd); end
      checks++; if (mem_Error !== e.err) begin errors++; $display("FAIL wr_rd_err[%0d]: got %b want %b", i, mem_Error, e.err); end
    end
    release_req();
  endtask

  // Preload words 0 and 1, then load them with no idle gap between requests.
  task automatic test_back_to_back();
    logic [31:0] ad [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] wd [4] = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
    logic        wr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int n; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ad[i], wd[i], wr[i], !wr[i]);
      wait_done(n);
      e = sb.pop_front();
      checks++; if (n !== WS + 1) begin errors++; $display("FAIL b2b_stall[%0d]: got %0d want %0d", i, n, WS + 1); end
      checks++; if (mem_RdData !== e.rd) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, mem_RdData, e.rd); end
      checks++; if (mem_Error !== e.err) begin errors++; $display("FAIL b2b_err[%0d]: got %b want %b", i, mem_Error, e.err); end
    end
    release_req();
  endtask

  // Misaligned load, then misaligned store into word 4 and readback of word 4.
  task automatic test_misaligned();
    logic [31:0] ad [3] = '{32'h6, 32'h12, 32'h10};
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    int n; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(ad[i], 32'hFFFFFFFF, wr[i], !wr[i]);
      wait_done(n);
      e = sb.pop_front();
      checks++; if (n !== WS + 1) begin errors++; $display("FAIL mis_stall[%0d]: got %0d want %0d", i, n, WS + 1); end
      checks++; if (mem_RdData !== e.rd) begin errors++; $display("FAIL mis_data[%0d]: got %h want %h", i, mem_RdData, e.rd); end
      checks++; if (mem_Error !== e.err) begin errors++; $display("FAIL mis_err[%0d]: got %b want %b", i, mem_Error, e.err); end
      release_req();
      @(negedge clock);
      checks++; if (mem_Error !== 1'b0) begin errors++; $display("FAIL mis_err_pulse[%0d]: got %b want 0", i, mem_Error); end
      checks++; if (mem_Stall !== 1'b0) begin errors++; $display("FAIL mis_reaccept[%0d]: got stall %b want 0", i, mem_Stall); end
    end
  endtask

  // Store just past the top of the RAM, then confirm word 0 is intact.
  task automatic test_out_of_range();
    logic [31:0] ad [2] = '{BASE + 32'd4 * (32'd1 << AW), BASE};
    logic        wr [2] = '{1'b1, 1'b0};
    int n; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(ad[i], 32'hA5A5A5A5, wr[i], !wr[i]);
      wait_done(n);
      e = sb.pop_front();
      checks++; if (n !== WS + 1) begin errors++; $display("FAIL oor_stall[%0d]: got %0d want %0d", i, n, WS + 1); end
      checks++; if (mem_RdData !== e.rd) begin errors++; $display("FAIL oor_data[%0d]: got %h want %h", i, mem_RdData, e.rd); end
      checks++; if (mem_Error !== e.err) begin errors++; $display("FAIL oor_err[%0d]: got %b want %b", i, mem_Error, e.err); end
    end
    release_req();
  endtask

  // Both enables high on a good address: write commits, error reported.
  task automatic test_both_enables();
    logic rd [2] = '{1'b1, 1'b1};
    logic wr [2] = '{1'b1, 1'b0};
    int n; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(32'h20, 32'h0BADF00D, wr[i], rd[i]);
      wait_done(n);
      e = sb.pop_front();
      checks++; if (n !== WS + 1) begin errors++; $display("FAIL both_stall[%0d]: got %0d want %0d", i, n, WS + 1); end
      checks++; if (mem_RdData !== e.rd) begin errors++; $display("FAIL both_data[%0d]: got %h want %h", i, mem_RdData, e.rd); end
      checks++; if (mem_Error !== e.err) begin errors++; $display("FAIL both_err[%0d]: got %b want %b", i, mem_Error, e.err); end
    end
    release_req();
  endtask

  // Reset lands in WAIT before the commit edge of a store to word 3.
  task automatic test_reset_mid_access();
    int n; exp_t e;
    issue(32'hC, 32'h33333333, 1'b1, 1'b0);
    wait_done(n);
    e = sb.pop_front();
    checks++; if (mem_Error !== e.err) begin errors++; $display("FAIL rst_pre_err: got %b want %b", mem_Error, e.err); end
    release_req();
    @(posedge clock);
    #1;
    mem_Addr = 32'hC; mem_WrData = 32'h12345678; mem_WrEn = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_Stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", mem_Stall); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (mem_RdData !== 32'h0) begin errors++; $display("FAIL rst_mid_rddata: got %h want 0", mem_RdData); end
    checks++; if (mem_Error !== 1'b0) begin errors++; $display("FAIL rst_mid_error: got %b want 0", mem_Error); end
    mem_WrEn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    last_rd = 32'h0;
    issue(32'hC, 32'h0, 1'b0, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    checks++; if (n !== WS + 1) begin errors++; $display("FAIL rst_rb_stall: got %0d want %0d", n, WS + 1); end
    checks++; if (mem_RdData !== e.rd) begin errors++; $display("FAIL rst_rb_data: got %h want %h", mem_RdData, e.rd); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_misaligned();
    test_out_of_range();
    test_both_enables();
    test_reset_mid_access();
    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the data-memory port driven by the pipeline's memory stage: accepts the stage's address, write data, write-enable and read-enable, and serves them from an on-chip word RAM with a programmable number of wait states. A stall output holds the pipeline steady until each access completes. Misaligned and out-of-range accesses are flagged without hanging the handshake. Sits between the memory stage's external-memory outputs and the data RAM.

## Interface
- ADDR_WIDTH, 10: word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 2: wait cycles per access; legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- mem_Addr  input  32  byte address of the access.
- mem_WrData  input  32  store data.
- mem_WrEn  input  1  store request.
- mem_RdEn  input  1  load request.
- mem_RdData  output  32  load data; valid in the completion cycle, held until next load completes.
- mem_Stall  output  1  pipeline must hold all request inputs while high.
- mem_Error  output  1  one-cycle pulse in completion cycle of a faulting access.

## Operation
- Request = mem_WrEn | mem_RdEn. If both are high, the access is a write and mem_Error pulses on completion.
- FSM states IDLE, WAIT, DONE (encoding in package).
- IDLE: no request -> stay, mem_Stall=0. Request -> latch addr, wdata, op, fault; load cnt=WAIT_STATES-1; go WAIT; mem_Stall=1 this cycle (combinational).
- WAIT: mem_Stall=1. cnt!=0 -> decrement. cnt==0 -> perform RAM access at this edge (write commits, read data registered into mem_RdData) unless faulted; go DONE.
- DONE: mem_Stall=0; pipeline advances at this edge; mem_Error=fault; unconditionally return to IDLE. The request still visible during DONE is never re-accepted.
- Fault = mem_Addr[1:0]!=0, or word offset (mem_Addr-BASE_ADDR)>>2 >= 2**ADDR_WIDTH, or mem_Addr<BASE_ADDR, or both enables high with a bad address. A faulted write does not modify RAM. A faulted read loads mem_RdData with 0.
- Both enables high with a good address: write performed, mem_Error=1.
- Latched inputs are used for the access; input changes during stall are ignored, which is a protocol violation by the driver.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset values: mem_RdData=0, mem_Stall=0, mem_Error=0, state=IDLE, cnt=0.
- Access latency: the request is first seen in cycle T. mem_Stall is high in cycles T..T+WAIT_STATES. DONE (completion) occurs in cycle T+WAIT_STATES+1.
- WAIT_STATES=1 gives a 3-cycle access with 2 stall cycles.
- Back-to-back: the next request is accepted in the IDLE cycle immediately after DONE. Throughput is one access per WAIT_STATES+2 cycles.
- Reset asserted mid-access (IDLE-accept or WAIT):
  - returns to IDLE immediately, and mem_Stall drops asynchronously;
  - a write is not committed unless its RAM edge already occurred;
  - mem_RdData=0.
- mem_Error is high only in DONE; never high with mem_Stall.

## Structure
- Package data_mem_pkg: state typedef/localparams (IDLE, WAIT, DONE), op encoding (OP_RD, OP_WR), WAIT_STATES legal-range constants.
- Sub-module sync_word_ram: single-port, 2**ADDR_WIDTH x 32, synchronous write and registered read, enable-gated, no reset on the array.
- Top holds the FSM, wait counter, request latches, fault decode and output registers.

## Test plan
- Write then read, WAIT_STATES=2: store 32'hDEADBEEF at 32'h0000_0010, then load 32'h0000_0010. Required: stall 3 cycles each; mem_RdData=32'hDEADBEEF in the load's DONE cycle; mem_Error=0.
- Back-to-back loads of words 0 and 1, preloaded with 32'h11111111 and 32'h22222222. Required: second accept in the cycle after first DONE; data in order; no re-accept of the first request during its DONE.
- Misaligned load at 32'h0000_0006. Required: stall WAIT_STATES+1 cycles; mem_RdData=0; mem_Error pulses 1 cycle; no RAM write.
- Out-of-range store at BASE_ADDR+4*2**ADDR_WIDTH, data 32'hA5A5A5A5. Required: mem_Error pulse; readback of word 0 unchanged.
- Reset during WAIT of a store of 32'h12345678 to word 3, asserted before the commit edge. Required: mem_Stall=0 immediately; state IDLE; word 3 retains its old value; outputs at reset values.
- Both enables high, good address 32'h0000_0020, data 32'h0BADF00D. Required: write commits; mem_Error=1 in DONE; subsequent load returns 32'h0BADF00D.
